// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM state type,
// default memory depth and the load-data extension helper.
package load_store_unit_pkg;

   localparam int unsigned LSU_DEPTH = 4096;

   localparam logic [2:0] FUNCT3_LB  = 3'b000;
   localparam logic [2:0] FUNCT3_LH  = 3'b001;
   localparam logic [2:0] FUNCT3_LW  = 3'b010;
   localparam logic [2:0] FUNCT3_LBU = 3'b100;
   localparam logic [2:0] FUNCT3_LHU = 3'b101;
   localparam logic [2:0] FUNCT3_SB  = 3'b000;
   localparam logic [2:0] FUNCT3_SH  = 3'b001;
   localparam logic [2:0] FUNCT3_SW  = 3'b010;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } lsu_state_t;

   // Extends raw memory data by load width/sign; memory-side extension is ignored.
   function automatic logic [31:0] lsu_extend(input logic [2:0] funct3, input logic [31:0] data);
      logic [31:0] ext;
      case (funct3)
         FUNCT3_LB:  ext = {{24{data[7]}}, data[7:0]};
         FUNCT3_LH:  ext = {{16{data[15]}}, data[15:0]};
         FUNCT3_LBU: ext = {24'h0, data[7:0]};
         FUNCT3_LHU: ext = {16'h0, data[15:0]};
         default:    ext = data;
      endcase
      return ext;
   endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Pipeline-side request/response bundle of the load/store unit.
interface load_store_unit_if;

   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata,
      output req_ready, resp_valid, resp_rdata, resp_err
   );

endinterface

// File: rtl/load_store_unit_align_check.sv
// Combinational legality check of a request: funct3 code, natural alignment
// and whole-access range against the memory depth.
module lsu_align_check
   import load_store_unit_pkg::*;
#(
   parameter int unsigned DEPTH = LSU_DEPTH
) (
   input  logic        we,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   output logic        err
);

   logic        funct_ok;
   logic        misaligned;
   logic        out_of_range;
   logic [32:0] size;
   logic [32:0] last_byte;

   always_comb begin
      funct_ok = 1'b0;
      if (we) begin
         funct_ok = (funct3 == FUNCT3_SB) || (funct3 == FUNCT3_SH) || (funct3 == FUNCT3_SW);
      end else begin
         funct_ok = (funct3 == FUNCT3_LB) || (funct3 == FUNCT3_LH) || (funct3 == FUNCT3_LW) ||
                    (funct3 == FUNCT3_LBU) || (funct3 == FUNCT3_LHU);
      end

      case (funct3[1:0])
         2'b00:   size = 33'd1;
         2'b01:   size = 33'd2;
         default: size = 33'd4;
      endcase

      misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                   ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));

      // 33-bit arithmetic so an access near 2^32 cannot wrap back into range.
      last_byte    = {1'b0, addr} + size - 33'd1;
      out_of_range = ({1'b0, addr} >= 33'(DEPTH)) || (last_byte >= 33'(DEPTH));

      err = !funct_ok || misaligned || out_of_range;
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one pipeline request at a time, drives a single-cycle
// memory strobe, extends load data and returns a one-cycle response.
module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter int unsigned DEPTH = LSU_DEPTH,
   parameter int unsigned ADDRW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   load_store_unit_if.slave bus,
   output logic             busy,
   output logic             mem_write_data,
   output logic             mem_read_data,
   output logic [ADDRW-1:0] mem_addr,
   output logic [2:0]       mem_sel,
   output logic [31:0]      mem_data_in,
   input  logic [31:0]      mem_data_out
);

   lsu_state_t       state_q;
   logic             we_q;
   logic [2:0]       funct3_q;
   logic             resp_valid_q;
   logic             resp_err_q;
   logic [31:0]      resp_rdata_q;
   logic             mem_write_q;
   logic             mem_read_q;
   logic [ADDRW-1:0] mem_addr_q;
   logic [2:0]       mem_sel_q;
   logic [31:0]      mem_data_in_q;
   logic             req_err;

   lsu_align_check #(
      .DEPTH (DEPTH)
   ) u_align_check (
      .we     (bus.req_we),
      .funct3 (bus.req_funct3),
      .addr   (bus.req_addr),
      .err    (req_err)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         we_q          <= 1'b0;
         funct3_q      <= 3'b000;
         resp_valid_q  <= 1'b0;
         resp_err_q    <= 1'b0;
         resp_rdata_q  <= 32'h0;
         mem_write_q   <= 1'b0;
         mem_read_q    <= 1'b0;
         mem_addr_q    <= '0;
         mem_sel_q     <= 3'b000;
         mem_data_in_q <= 32'h0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (bus.req_valid) begin
                  we_q     <= bus.req_we;
                  funct3_q <= bus.req_funct3;
                  if (req_err) begin
                     // Errors skip memory entirely so the memory-side bus keeps its last value.
                     resp_valid_q <= 1'b1;
                     resp_err_q   <= 1'b1;
                     resp_rdata_q <= 32'h0;
                     state_q      <= RESP;
                  end else begin
                     mem_write_q   <= bus.req_we;
                     mem_read_q    <= !bus.req_we;
                     mem_addr_q    <= bus.req_addr[ADDRW-1:0];
                     mem_sel_q     <= bus.req_funct3;
                     mem_data_in_q <= bus.req_wdata;
                     state_q       <= ACCESS;
                  end
               end
            end
            ACCESS: begin
               mem_write_q  <= 1'b0;
               mem_read_q   <= 1'b0;
               resp_valid_q <= 1'b1;
               resp_err_q   <= 1'b0;
               resp_rdata_q <= we_q ? 32'h0 : lsu_extend(funct3_q, mem_data_out);
               state_q      <= RESP;
            end
            RESP: begin
               resp_valid_q <= 1'b0;
               state_q      <= IDLE;
            end
            default: begin
               mem_write_q  <= 1'b0;
               mem_read_q   <= 1'b0;
               resp_valid_q <= 1'b0;
               state_q      <= IDLE;
            end
         endcase
      end
   end

   assign bus.req_ready  = (state_q == IDLE);
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_err   = resp_err_q;
   assign bus.resp_rdata = resp_rdata_q;

   assign busy           = (state_q != IDLE);
   assign mem_write_data = mem_write_q;
   assign mem_read_data  = mem_read_q;
   assign mem_addr       = mem_addr_q;
   assign mem_sel        = mem_sel_q;
   assign mem_data_in    = mem_data_in_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit against a little-endian byte-array memory.
module tb_load_store_unit;

   localparam int unsigned DEPTH = 4096;
   localparam int unsigned ADDRW = 12;

   logic             clk;
   logic             rst;
   logic             busy;
   logic             mem_write_data;
   logic             mem_read_data;
   logic [ADDRW-1:0] mem_addr;
   logic [2:0]       mem_sel;
   logic [31:0]      mem_data_in;
   logic [31:0]      mem_data_out;

   logic [7:0]       mem [DEPTH];
   int               n_checks;
   int               n_errors;
   int               wr_cnt;
   int               rd_cnt;

   load_store_unit_if bus_if ();

   load_store_unit #(
      .DEPTH (DEPTH)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .bus            (bus_if),
      .busy           (busy),
      .mem_write_data (mem_write_data),
      .mem_read_data  (mem_read_data),
      .mem_addr       (mem_addr),
      .mem_sel        (mem_sel),
      .mem_data_in    (mem_data_in),
      .mem_data_out   (mem_data_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign mem_data_out = {mem[mem_addr + 12'd3], mem[mem_addr + 12'd2],
                          mem[mem_addr + 12'd1], mem[mem_addr]};

   always @(posedge clk) begin
      if (mem_write_data) begin
         wr_cnt <= wr_cnt + 1;
         case (mem_sel)
            3'b000: mem[mem_addr] <= mem_data_in[7:0];
            3'b001: begin
               mem[mem_addr]         <= mem_data_in[7:0];
               mem[mem_addr + 12'd1] <= mem_data_in[15:8];
            end
            default: begin
               mem[mem_addr]         <= mem_data_in[7:0];
               mem[mem_addr + 12'd1] <= mem_data_in[15:8];
               mem[mem_addr + 12'd2] <= mem_data_in[23:16];
               mem[mem_addr + 12'd3] <= mem_data_in[31:24];
            end
         endcase
      end
      if (mem_read_data) rd_cnt <= rd_cnt + 1;
   end

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Issues one request, then scrambles req_* to show later changes are ignored.
   task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, output int lat, output logic [31:0] rdata,
                        output logic err);
      int w;
      w = 0;
      @(negedge clk);
      while (!bus_if.req_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      bus_if.req_we     = we;
      bus_if.req_funct3 = f3;
      bus_if.req_addr   = addr;
      bus_if.req_wdata  = wdata;
      bus_if.req_valid  = 1'b1;
      @(posedge clk);
      #1;
      bus_if.req_valid  = 1'b0;
      bus_if.req_we     = ~we;
      bus_if.req_funct3 = ~f3;
      bus_if.req_addr   = 32'hFFFF_FFFF;
      bus_if.req_wdata  = 32'h5555_AAAA;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!bus_if.resp_valid && lat < 8);
      rdata = bus_if.resp_rdata;
      err   = bus_if.resp_err;
   endtask

   task automatic run_case(input string tag, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] exp_rdata, input logic exp_err);
      int          lat;
      logic [31:0] rdata;
      logic        err;
      int          wr0;
      int          rd0;
      logic [7:0]  exp_strb;
      wr0 = wr_cnt;
      rd0 = rd_cnt;
      issue(we, f3, addr, wdata, lat, rdata, err);
      exp_strb = exp_err ? 8'h00 : (we ? 8'h10 : 8'h01);
      check_value({tag, "_lat"}, 32'(lat), exp_err ? 32'd1 : 32'd2);
      check_value({tag, "_rdata"}, rdata, exp_rdata);
      check_value({tag, "_err"}, {31'h0, err}, {31'h0, exp_err});
      check_value({tag, "_strobes"}, {24'h0, 4'(wr_cnt - wr0), 4'(rd_cnt - rd0)}, {24'h0, exp_strb});
   endtask

   initial begin
      int cyc;
      int acc;
      int last;
      int busy_bad;
      int seen_resp;
      int seen_strb;
      logic rdy;

      n_checks          = 0;
      n_errors          = 0;
      wr_cnt            = 0;
      rd_cnt            = 0;
      // A store presented during reset must not be accepted.
      rst               = 1'b1;
      bus_if.req_valid  = 1'b1;
      bus_if.req_we     = 1'b1;
      bus_if.req_funct3 = 3'b010;
      bus_if.req_addr   = 32'h80;
      bus_if.req_wdata  = 32'hCAFE_F00D;
      repeat (3) @(posedge clk);
      #1;
      rst              = 1'b0;
      bus_if.req_valid = 1'b0;
      @(negedge clk);
      check_value("rst_resp", {29'h0, bus_if.resp_valid, bus_if.resp_err, busy}, 32'h0);
      check_value("rst_rdata", bus_if.resp_rdata, 32'h0);
      check_value("rst_mem", {15'h0, mem_write_data, mem_read_data, mem_sel, mem_addr}, 32'h0);
      check_value("rst_wdata", mem_data_in, 32'h0);
      check_value("rst_ready", {31'h0, bus_if.req_ready}, 32'h1);
      check_value("rst_no_acc", 32'(wr_cnt + rd_cnt), 32'h0);

      run_case("sw10", 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0);
      check_value("sw10_mem", {mem[32'h13], mem[32'h12], mem[32'h11], mem[32'h10]}, 32'hDEAD_BEEF);
      run_case("lw10", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);
      run_case("lb13", 1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFF_FFDE, 1'b0);
      run_case("lbu13", 1'b0, 3'b100, 32'h13, 32'h0, 32'h0000_00DE, 1'b0);
      run_case("lh12", 1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFF_DEAD, 1'b0);
      run_case("lhu10", 1'b0, 3'b101, 32'h10, 32'h0, 32'h0000_BEEF, 1'b0);
      run_case("sb30", 1'b1, 3'b000, 32'h30, 32'h1234_5681, 32'h0, 1'b0);
      run_case("lb30", 1'b0, 3'b000, 32'h30, 32'h0, 32'hFFFF_FF81, 1'b0);

      run_case("lw11", 1'b0, 3'b010, 32'h11, 32'h0, 32'h0, 1'b1);
      run_case("sh05", 1'b1, 3'b001, 32'h05, 32'hFFFF, 32'h0, 1'b1);
      run_case("lwffe", 1'b0, 3'b010, 32'hFFE, 32'h0, 32'h0, 1'b1);
      run_case("lw1000", 1'b0, 3'b010, 32'h1000, 32'h0, 32'h0, 1'b1);
      run_case("ld011", 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1);
      run_case("st100", 1'b1, 3'b100, 32'h10, 32'h0, 32'h0, 1'b1);
      // Memory-side bus keeps the last valid access (LB 0x30) across error requests.
      check_value("err_hold", {17'h0, mem_sel, mem_addr}, {17'h0, 3'b000, 12'h030});
      run_case("swffc", 1'b1, 3'b010, 32'hFFC, 32'h0BAD_F00D, 32'h0, 1'b0);
      run_case("lwffc", 1'b0, 3'b010, 32'hFFC, 32'h0, 32'h0BAD_F00D, 1'b0);

      // Four stores with req_valid held high: accepts spaced exactly 3 cycles.
      cyc      = 0;
      acc      = 0;
      last     = 0;
      busy_bad = 0;
      @(negedge clk);
      bus_if.req_we     = 1'b1;
      bus_if.req_funct3 = 3'b010;
      bus_if.req_addr   = 32'h20;
      bus_if.req_wdata  = 32'hA000_0000;
      bus_if.req_valid  = 1'b1;
      while (acc < 4 && cyc < 40) begin
         rdy = bus_if.req_ready;
         if (!rdy && !busy) busy_bad++;
         @(posedge clk);
         if (rdy) begin
            if (acc > 0) check_value("b2b_gap", 32'(cyc - last), 32'd3);
            last = cyc;
            acc++;
            #1;
            bus_if.req_addr  = 32'h20 + 32'(4 * acc);
            bus_if.req_wdata = 32'hA000_0000 + 32'(acc);
            if (acc == 4) bus_if.req_valid = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      repeat (3) @(negedge clk);
      check_value("b2b_count", 32'(acc), 32'd4);
      check_value("b2b_busy", 32'(busy_bad), 32'd0);
      check_value("b2b_m20", {mem[32'h23], mem[32'h22], mem[32'h21], mem[32'h20]}, 32'hA000_0000);
      check_value("b2b_m24", {mem[32'h27], mem[32'h26], mem[32'h25], mem[32'h24]}, 32'hA000_0001);
      check_value("b2b_m28", {mem[32'h2B], mem[32'h2A], mem[32'h29], mem[32'h28]}, 32'hA000_0002);
      check_value("b2b_m2c", {mem[32'h2F], mem[32'h2E], mem[32'h2D], mem[32'h2C]}, 32'hA000_0003);

      // Reset pulsed in the ACCESS cycle of a store aborts it.
      @(negedge clk);
      bus_if.req_we     = 1'b1;
      bus_if.req_funct3 = 3'b010;
      bus_if.req_addr   = 32'h40;
      bus_if.req_wdata  = 32'h1234_5678;
      bus_if.req_valid  = 1'b1;
      @(posedge clk);
      #1;
      bus_if.req_valid = 1'b0;
      rst              = 1'b1;
      @(posedge clk);
      #1;
      rst       = 1'b0;
      seen_resp = 0;
      seen_strb = 0;
      repeat (4) begin
         @(negedge clk);
         if (bus_if.resp_valid) seen_resp++;
         if (mem_write_data || mem_read_data) seen_strb++;
      end
      check_value("abort_resp", 32'(seen_resp), 32'd0);
      check_value("abort_strb", 32'(seen_strb), 32'd0);
      check_value("abort_addr", {20'h0, mem_addr}, 32'h0);
      run_case("post_lw10", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
